st_data_format_adapter_32to8: RTL

- Avalon-ST data-format adapter sitting directly downstream of the 32-bit timing adapter.
- Consumes 32-bit beats with sop/eop/empty and emits one 8-bit symbol per beat, suitable for a byte-wide sink.
- Symbol order is big-endian per Avalon-ST: in_data[31:24] is sent first.
- Throughput is 1 byte/cycle sustained across word and packet boundaries; no bubbles when out_ready stays high.

---
 rtl/st_adapter_pkg.sv | 18 +
 rtl/st_data_format_adapter_32to8.sv | 86 ++++++++
 2 files changed

// File: rtl/st_adapter_pkg.sv
// Shared definitions for the Avalon-ST width adapters.
package st_adapter_pkg;

  localparam int SYMBOL_WIDTH     = 8;
  localparam int SYMBOLS_PER_BEAT = 4;
  localparam int EMPTY_WIDTH      = 2;

  // Index of the last valid symbol in a beat. Symbols are counted from the
  // MSB end and empty counts from the LSB end. Because SYMBOLS_PER_BEAT is
  // 2**EMPTY_WIDTH, (SYMBOLS_PER_BEAT-1-empty) is simply ~empty.
  function automatic logic [EMPTY_WIDTH-1:0] calc_last_idx(
    input logic                   eop,
    input logic [EMPTY_WIDTH-1:0] empty
  );
    return eop ? ~empty : {EMPTY_WIDTH{1'b1}};
  endfunction

endpackage

// File: rtl/st_data_format_adapter_32to8.sv
// Avalon-ST data-format adapter: 32-bit beats in, one 8-bit symbol per cycle
// out, big-endian symbol order. A single holding register plus a symbol index;
// a new beat may load in the same cycle the last symbol leaves, so throughput
// stays at one symbol per cycle across word and packet boundaries.
module st_data_format_adapter_32to8 #(
  parameter int SYMBOL_WIDTH     = st_adapter_pkg::SYMBOL_WIDTH,
  parameter int SYMBOLS_PER_BEAT = st_adapter_pkg::SYMBOLS_PER_BEAT,
  parameter int EMPTY_WIDTH      = st_adapter_pkg::EMPTY_WIDTH
) (
  input  logic                                   clk,
  input  logic                                   reset_n,
  output logic                                   in_ready,
  input  logic                                   in_valid,
  input  logic [SYMBOL_WIDTH*SYMBOLS_PER_BEAT-1:0] in_data,
  input  logic                                   in_startofpacket,
  input  logic                                   in_endofpacket,
  input  logic [EMPTY_WIDTH-1:0]                 in_empty,
  input  logic                                   out_ready,
  output logic                                   out_valid,
  output logic [SYMBOL_WIDTH-1:0]                out_data,
  output logic                                   out_startofpacket,
  output logic                                   out_endofpacket
);
  import st_adapter_pkg::*;

  localparam int DATA_WIDTH = SYMBOL_WIDTH * SYMBOLS_PER_BEAT;

  logic                    r_hold_valid;
  logic [DATA_WIDTH-1:0]   r_hold_word;
  logic                    r_hold_sop;
  logic                    r_hold_eop;
  logic [EMPTY_WIDTH-1:0]  r_last_idx;
  logic [EMPTY_WIDTH-1:0]  r_idx;

  logic                    w_last_byte;
  logic                    w_accept;
  logic                    w_xfer;
  logic [SYMBOL_WIDTH-1:0] w_symbol;

  assign w_last_byte = r_hold_valid & (r_idx == r_last_idx);
  assign in_ready    = reset_n & (~r_hold_valid | (out_ready & w_last_byte));
  assign w_accept    = in_valid & in_ready;
  assign w_xfer      = r_hold_valid & out_ready;

  // Select the current symbol; symbol 0 sits in the most significant bits.
  always_comb begin
    w_symbol = '0;
    for (int i = 0; i < SYMBOLS_PER_BEAT; i++) begin
      if (r_idx == EMPTY_WIDTH'(i)) begin
        w_symbol = r_hold_word[DATA_WIDTH-1-i*SYMBOL_WIDTH -: SYMBOL_WIDTH];
      end
    end
  end

  assign out_valid         = r_hold_valid;
  assign out_data          = w_symbol;
  assign out_startofpacket = r_hold_valid & r_hold_sop & (r_idx == '0);
  assign out_endofpacket   = r_hold_valid & r_hold_eop & (r_idx == r_last_idx);

  // Holding register and symbol index; a load in the last-symbol cycle wins
  // over clearing, which is what removes the gap between words.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_hold_valid <= 1'b0;
      r_hold_word  <= '0;
      r_hold_sop   <= 1'b0;
      r_hold_eop   <= 1'b0;
      r_last_idx   <= '1;
      r_idx        <= '0;
    end else if (w_accept) begin
      r_hold_valid <= 1'b1;
      r_hold_word  <= in_data;
      r_hold_sop   <= in_startofpacket;
      r_hold_eop   <= in_endofpacket;
      r_last_idx   <= calc_last_idx(in_endofpacket, in_empty);
      r_idx        <= '0;
    end else if (w_xfer) begin
      if (w_last_byte) begin
        r_hold_valid <= 1'b0;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

endmodule
